// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter.
//   - Size codes understood by dmem (and checked by dmem_align_chk).
//   - Arbiter state encoding.
package dmem_pkg;

    localparam logic [2:0] SZ_B    = 3'b000;  // byte, sign-extended
    localparam logic [2:0] SZ_H    = 3'b001;  // half, sign-extended
    localparam logic [2:0] SZ_W    = 3'b010;  // word
    localparam logic [2:0] SZ_BU   = 3'b100;  // byte, zero-extended
    localparam logic [2:0] SZ_HU   = 3'b101;  // half, zero-extended
    localparam logic [2:0] SZ_IDLE = 3'b011;  // illegal code, parks dmem

    typedef enum logic {
        ARB,
        BURST
    } arb_state_t;

endpackage

// File: rtl/dmem_align_chk.sv
// dmem_align_chk: combinational legality check for one memory access.
// Ports:
//   addr_i  [1:0]  low address bits
//   size_i  [2:0]  size code
//   we_i           1 = store
//   legal_o        access may be forwarded to dmem
module dmem_align_chk
    import dmem_pkg::*;
(
    input  logic [1:0] addr_i,
    input  logic [2:0] size_i,
    input  logic       we_i,
    output logic       legal_o
);

    always_comb begin
        legal_o = 1'b0;
        case (size_i)
            SZ_B:    legal_o = 1'b1;
            SZ_BU:   legal_o = !we_i;                 // no unsigned stores
            SZ_H:    legal_o = !addr_i[0];
            SZ_HU:   legal_o = !addr_i[0] && !we_i;
            SZ_W:    legal_o = (addr_i == 2'b00);
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arb.sv
// dmem_arb: two-port arbiter/sequencer in front of dmem.
//   Port 0 = core load/store, port 1 = debug/DMA loader (may lock for bursts).
//   One access per cycle; illegal accesses are accepted but never reach dmem
//   and answer with err=1. Every accept gets a one-cycle response at T+1.
// Ports:
//   clk, rst                         clock, async active-high reset
//   req{0,1}_{valid,ready,addr,wdata,size,we}   request handshake + fields
//   req1_lock                        port 1 burst hold request
//   rsp{0,1}_{valid,err,rdata}       registered responses
//   mem_{addr,wData,size,wEn}        to dmem, mem_rData from dmem (comb read)
module dmem_arb
    import dmem_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [2:0]  req0_size,
    input  logic        req0_we,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [2:0]  req1_size,
    input  logic        req1_we,
    input  logic        req1_lock,

    output logic        rsp0_valid,
    output logic        rsp0_err,
    output logic [31:0] rsp0_rdata,
    output logic        rsp1_valid,
    output logic        rsp1_err,
    output logic [31:0] rsp1_rdata,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wData,
    output logic [2:0]  mem_size,
    output logic        mem_wEn,
    input  logic [31:0] mem_rData
);

    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t      state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [CW-1:0]   burst_cnt_q, burst_cnt_d;

    logic            rdy0, rdy1;
    logic [31:0]     m_addr, m_wdata;
    logic [2:0]      m_size;
    logic            m_we;
    logic            legal;
    logic            issue;

    // Grant: in BURST port 1 owns the memory; in ARB a lone requester wins
    // and a contested cycle goes to the port that was not granted last.
    always_comb begin
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        if (!rst) begin
            if (state_q == BURST) begin
                rdy1 = req1_valid;
            end else begin
                rdy0 = req0_valid && (!req1_valid ||  last_grant_q);
                rdy1 = req1_valid && (!req0_valid || !last_grant_q);
            end
        end
    end

    assign req0_ready = rdy0;
    assign req1_ready = rdy1;

    assign m_addr  = rdy1 ? req1_addr  : req0_addr;
    assign m_wdata = rdy1 ? req1_wdata : req0_wdata;
    assign m_size  = rdy1 ? req1_size  : req0_size;
    assign m_we    = rdy1 ? req1_we    : req0_we;

    dmem_align_chk u_chk (
        .addr_i  (m_addr[1:0]),
        .size_i  (m_size),
        .we_i    (m_we),
        .legal_o (legal)
    );

    // Only legal accepted accesses reach dmem; otherwise park it on an
    // illegal size code so it neither writes nor performs a read.
    assign issue     = (rdy0 || rdy1) && legal;
    assign mem_addr  = issue ? m_addr  : 32'h0;
    assign mem_wData = issue ? m_wdata : 32'h0;
    assign mem_size  = issue ? m_size  : SZ_IDLE;
    assign mem_wEn   = issue && m_we;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        case (state_q)
            ARB: begin
                if (rdy0) last_grant_d = 1'b0;
                if (rdy1) begin
                    last_grant_d = 1'b1;
                    if (req1_lock) begin
                        state_d     = BURST;
                        burst_cnt_d = CW'(1);
                    end
                end
            end
            BURST: begin
                // A beat presented with lock already low is still taken,
                // but ends the burst.
                if (!req1_lock || !req1_valid ||
                    (burst_cnt_q + CW'(1) == CW'(MAX_BURST))) begin
                    state_d     = ARB;
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q + CW'(1);
                end
                last_grant_d = 1'b1;  // port 0 wins the next contested cycle
            end
            default: begin
                state_d     = ARB;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB;
            last_grant_q <= 1'b1;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    logic        rsp0_valid_q, rsp1_valid_q, rsp0_err_q, rsp1_err_q;
    logic [31:0] rsp0_rdata_q, rsp1_rdata_q;
    logic [31:0] ld_data;

    assign ld_data = (legal && !m_we) ? mem_rData : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_err_q   <= 1'b0;
            rsp1_err_q   <= 1'b0;
            rsp0_rdata_q <= 32'h0;
            rsp1_rdata_q <= 32'h0;
        end else begin
            rsp0_valid_q <= rdy0;
            rsp1_valid_q <= rdy1;
            rsp0_err_q   <= rdy0 && !legal;
            rsp1_err_q   <= rdy1 && !legal;
            rsp0_rdata_q <= rdy0 ? ld_data : 32'h0;
            rsp1_rdata_q <= rdy1 ? ld_data : 32'h0;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_err   = rsp0_err_q;
    assign rsp1_err   = rsp1_err_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

endmodule
